// File: rtl/raster_pkg.sv
// Shared types for the raster scheduler: packed triangle layout, field offsets,
// counter width and the zero-area test used by the optional culling stage.
package raster_pkg;

  localparam int COORD_W = 16;
  localparam int TRI_W   = 6 * COORD_W;
  localparam int CNT_W   = 16;

  localparam int AX_LSB = 0;
  localparam int AY_LSB = 16;
  localparam int BX_LSB = 32;
  localparam int BY_LSB = 48;
  localparam int CX_LSB = 64;
  localparam int CY_LSB = 80;

  typedef struct packed {
    logic [COORD_W-1:0] c_y;
    logic [COORD_W-1:0] c_x;
    logic [COORD_W-1:0] b_y;
    logic [COORD_W-1:0] b_x;
    logic [COORD_W-1:0] a_y;
    logic [COORD_W-1:0] a_x;
  } tri_t;

  // Signed area (b-a)x(c-a) is zero exactly when its two 33-bit cross terms match,
  // which avoids needing an extra bit for their difference.
  function automatic logic tri_is_degenerate(tri_t t);
    logic signed [32:0] ax, ay, bx, by, cx, cy;
    logic signed [32:0] p_xy, p_yx;
    ax = 33'($signed(t.a_x));
    ay = 33'($signed(t.a_y));
    bx = 33'($signed(t.b_x));
    by = 33'($signed(t.b_y));
    cx = 33'($signed(t.c_x));
    cy = 33'($signed(t.c_y));
    p_xy = (bx - ax) * (cy - ay);
    p_yx = (by - ay) * (cx - ax);
    return p_xy == p_yx;
  endfunction

endpackage

// File: rtl/raster_sched_fifo.sv
// Triangle queue: DEPTH-entry circular buffer with occupancy counter and flush.
// Head output reads as zero while empty so no stale entry is ever presented.
module raster_sched_fifo
  import raster_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [TRI_W-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [TRI_W-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [TRI_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + (PTR_W+1)'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset: it is only visible through the occupancy-gated head.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/raster_sched.sv
// Two-requester round-robin triangle scheduler feeding one rasteriser through a FIFO.
// Define RASTER_SCHED_CULL_EN to drop zero-area triangles at acceptance.
module raster_sched
  import raster_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               raster_sched_clock_i,
  input  logic               raster_sched_reset_i,
  input  logic [TRI_W-1:0]   req0_tri_i,
  input  logic               req0_valid_i,
  output logic               req0_busy_o,
  input  logic [TRI_W-1:0]   req1_tri_i,
  input  logic               req1_valid_i,
  output logic               req1_busy_o,
  output logic [COORD_W-1:0] a_x_o,
  output logic [COORD_W-1:0] a_y_o,
  output logic [COORD_W-1:0] b_x_o,
  output logic [COORD_W-1:0] b_y_o,
  output logic [COORD_W-1:0] c_x_o,
  output logic [COORD_W-1:0] c_y_o,
  output logic               rast_valid_o,
  input  logic               rast_busy_i,
  input  logic               flush_i,
  output logic               idle_o,
  output logic [CNT_W-1:0]   tri_count_o,
  output logic [CNT_W-1:0]   cull_count_o
);

  logic             prio_q, prio_d;
  logic [CNT_W-1:0] tri_cnt_q, tri_cnt_d;
  logic             gnt0, gnt1, accept, cull, push, pop, full, empty;
  logic [TRI_W-1:0] acc_tri, head;

  // prio_q names the requester that wins when both are valid.
  assign gnt0 = req0_valid_i && (!req1_valid_i || !prio_q);
  assign gnt1 = req1_valid_i && (!req0_valid_i || prio_q);

  assign req0_busy_o = full || flush_i || gnt1;
  assign req1_busy_o = full || flush_i || gnt0;

  assign accept  = (gnt0 || gnt1) && !full && !flush_i;
  assign acc_tri = gnt1 ? req1_tri_i : req0_tri_i;
  assign push    = accept && !cull;
  assign pop     = !empty && !rast_busy_i && !flush_i;

  always_comb begin
    prio_d    = accept ? gnt0 : prio_q;
    tri_cnt_d = tri_cnt_q + CNT_W'(pop);
  end

  always_ff @(posedge raster_sched_clock_i or negedge raster_sched_reset_i) begin
    if (!raster_sched_reset_i) begin
      prio_q    <= 1'b0;
      tri_cnt_q <= '0;
    end else begin
      prio_q    <= prio_d;
      tri_cnt_q <= tri_cnt_d;
    end
  end

`ifdef RASTER_SCHED_CULL_EN
  logic [CNT_W-1:0] cull_cnt_q, cull_cnt_d;

  assign cull       = tri_is_degenerate(tri_t'(acc_tri));
  assign cull_cnt_d = cull_cnt_q + CNT_W'(accept && cull);

  always_ff @(posedge raster_sched_clock_i or negedge raster_sched_reset_i) begin
    if (!raster_sched_reset_i) cull_cnt_q <= '0;
    else                       cull_cnt_q <= cull_cnt_d;
  end

  assign cull_count_o = cull_cnt_q;
`else
  assign cull         = 1'b0;
  assign cull_count_o = '0;
`endif

  raster_sched_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (raster_sched_clock_i),
    .rst_ni  (raster_sched_reset_i),
    .push_i  (push),
    .data_i  (acc_tri),
    .pop_i   (pop),
    .flush_i (flush_i),
    .data_o  (head),
    .empty_o (empty),
    .full_o  (full)
  );

  assign a_x_o        = head[AX_LSB +: COORD_W];
  assign a_y_o        = head[AY_LSB +: COORD_W];
  assign b_x_o        = head[BX_LSB +: COORD_W];
  assign b_y_o        = head[BY_LSB +: COORD_W];
  assign c_x_o        = head[CX_LSB +: COORD_W];
  assign c_y_o        = head[CY_LSB +: COORD_W];
  assign rast_valid_o = !empty;
  assign idle_o       = empty;
  assign tri_count_o  = tri_cnt_q;

endmodule

// File: tb/tb_raster_sched.sv
// Self-checking bench for raster_sched: directed scenarios plus a randomized run
// against a queue-based reference model. Inputs change on the falling edge.
module tb_raster_sched;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [95:0] t0 = '0, t1 = '0;
  logic        v0 = 1'b0, v1 = 1'b0, rbusy = 1'b0, flush = 1'b0;
  logic        b0, b1, rvalid, idle;
  logic [15:0] ax, ay, bx, by, cx, cy, tcnt, ccnt;
  logic [95:0] head;
  int          n_cmp = 0;
  int          n_err = 0;

  assign head = {cy, cx, by, bx, ay, ax};

  raster_sched #(.FIFO_DEPTH(DEPTH)) dut (
    .raster_sched_clock_i (clk),
    .raster_sched_reset_i (rst_n),
    .req0_tri_i           (t0),
    .req0_valid_i         (v0),
    .req0_busy_o          (b0),
    .req1_tri_i           (t1),
    .req1_valid_i         (v1),
    .req1_busy_o          (b1),
    .a_x_o                (ax),
    .a_y_o                (ay),
    .b_x_o                (bx),
    .b_y_o                (by),
    .c_x_o                (cx),
    .c_y_o                (cy),
    .rast_valid_o         (rvalid),
    .rast_busy_i          (rbusy),
    .flush_i              (flush),
    .idle_o               (idle),
    .tri_count_o          (tcnt),
    .cull_count_o         (ccnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit tri_flat(logic [95:0] t);
    longint pax, pay, pbx, pby, pcx, pcy;
    pax = longint'($signed(t[15:0]));
    pay = longint'($signed(t[31:16]));
    pbx = longint'($signed(t[47:32]));
    pby = longint'($signed(t[63:48]));
    pcx = longint'($signed(t[79:64]));
    pcy = longint'($signed(t[95:80]));
    return ((pbx - pax) * (pcy - pay) - (pby - pay) * (pcx - pax)) == 0;
  endfunction

  // Right-angle triangle with non-zero legs: never culled.
  function automatic logic [95:0] good_tri();
    logic [15:0] gx, gy, dx, dy;
    gx = 16'($urandom_range(0, 1000));
    gy = 16'($urandom_range(0, 1000));
    dx = 16'($urandom_range(1, 200));
    dy = 16'($urandom_range(1, 200));
    return {gy + dy, gx, gy, gx + dx, gy, gx};
  endfunction

  // Mix of arbitrary and collinear triangles.
  function automatic logic [95:0] rnd_tri();
    logic [15:0] gx, gy, dx, dy;
    if ($urandom_range(0, 3) == 0) begin
      gx = 16'($urandom_range(0, 1000));
      gy = 16'($urandom_range(0, 1000));
      dx = 16'($urandom_range(0, 100));
      dy = 16'($urandom_range(0, 100));
      return {gy + 16'(2) * dy, gx + 16'(2) * dx, gy + dy, gx + dx, gy, gx};
    end
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input logic a0, input logic a1, input logic [95:0] d0,
                       input logic [95:0] d1, input logic rb, input logic fl);
    v0 = a0; v1 = a1; t0 = d0; t1 = d1; rbusy = rb; flush = fl;
  endtask

  task automatic do_reset();
    drive(0, 0, '0, '0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", rvalid); end
    n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle got=%b want=1", idle); end
    n_cmp++; if ({b0, b1} !== 2'b00) begin n_err++; $display("FAIL reset_busy got=%b want=00", {b0, b1}); end
    n_cmp++; if (head !== 96'd0) begin n_err++; $display("FAIL reset_head got=%h want=0", head); end
    n_cmp++; if ({tcnt, ccnt} !== 32'd0) begin n_err++; $display("FAIL reset_counts got=%h want=0", {tcnt, ccnt}); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [95:0] l0 [3];
    logic [95:0] l1 [3];
    logic [95:0] got [$];
    logic [95:0] want;
    int i0 = 0, i1 = 0;
    logic acc0, acc1;
    do_reset();
    for (int k = 0; k < 3; k++) begin l0[k] = good_tri(); l1[k] = good_tri(); end
    for (int cyc = 0; cyc < 40 && got.size() < 6; cyc++) begin
      drive(i0 < 3, i1 < 3, (i0 < 3) ? l0[i0] : '0, (i1 < 3) ? l1[i1] : '0, 0, 0);
      #1;
      if (rvalid && !rbusy) begin
        got.push_back(head);
        $display("rr issue %0d tri=%h", got.size(), head);
      end
      acc0 = v0 && !b0;
      acc1 = v1 && !b1;
      @(posedge clk);
      if (acc0) i0++;
      if (acc1) i1++;
      @(negedge clk);
    end
    n_cmp++; if (got.size() != 6) begin n_err++; $display("FAIL rr_pops got=%0d want=6", got.size()); end
    for (int k = 0; k < 6; k++) begin
      want = (k % 2 == 0) ? l0[k/2] : l1[k/2];
      if (k < got.size()) begin
        n_cmp++;
        if (got[k] !== want) begin n_err++; $display("FAIL rr_order[%0d] got=%h want=%h", k, got[k], want); end
      end
    end
    #1;
    n_cmp++; if (tcnt !== 16'd6) begin n_err++; $display("FAIL rr_tri_count got=%0d want=6", tcnt); end
  endtask

  task automatic test_backpressure_and_flush();
    logic [95:0] l [5];
    do_reset();
    for (int k = 0; k < 5; k++) l[k] = good_tri();
    for (int cyc = 0; cyc < 5; cyc++) begin
      drive(1, 0, l[cyc], '0, 1, 0);
      #1;
      $display("bp offer %0d busy=%b", cyc, b0);
      n_cmp++;
      if (b0 !== (cyc >= 4)) begin n_err++; $display("FAIL bp_busy[%0d] got=%b want=%b", cyc, b0, cyc >= 4); end
      if (cyc == 4) begin
        n_cmp++; if (rvalid !== 1'b1) begin n_err++; $display("FAIL bp_valid got=%b want=1", rvalid); end
        n_cmp++; if (head !== l[0]) begin n_err++; $display("FAIL bp_head got=%h want=%h", head, l[0]); end
      end
      next_cycle();
    end
    drive(1, 0, l[4], '0, 0, 1);
    #1;
    n_cmp++; if ({b0, b1} !== 2'b11) begin n_err++; $display("FAIL flush_busy got=%b want=11", {b0, b1}); end
    next_cycle();
    drive(0, 0, '0, '0, 0, 0);
    #1;
    n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL flush_idle got=%b want=1", idle); end
    n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL flush_valid got=%b want=0", rvalid); end
    n_cmp++; if (tcnt !== 16'd0) begin n_err++; $display("FAIL flush_tri_count got=%0d want=0", tcnt); end
    @(negedge clk);
  endtask

  task automatic test_latency();
    logic [95:0] t;
    t = good_tri();
    drive(0, 1, '0, t, 0, 0);
    #1;
    n_cmp++; if ({b1, rvalid, idle} !== 3'b001) begin n_err++; $display("FAIL lat_n got=%b want=001", {b1, rvalid, idle}); end
    next_cycle();
    drive(0, 0, '0, '0, 0, 0);
    #1;
    n_cmp++; if (rvalid !== 1'b1) begin n_err++; $display("FAIL lat_n1_valid got=%b want=1", rvalid); end
    n_cmp++; if (head !== t) begin n_err++; $display("FAIL lat_n1_head got=%h want=%h", head, t); end
    next_cycle();
    #1;
    n_cmp++; if ({idle, rvalid} !== 2'b10) begin n_err++; $display("FAIL lat_n2 got=%b want=10", {idle, rvalid}); end
    n_cmp++; if (tcnt !== 16'd1) begin n_err++; $display("FAIL lat_tri_count got=%0d want=1", tcnt); end
    @(negedge clk);
  endtask

  task automatic test_cull();
    logic [95:0] flat, ok;
    logic        exp_valid;
    logic [15:0] exp_cull, exp_tri;
    flat = {16'd8, 16'd8, 16'd4, 16'd4, 16'd0, 16'd0};
    ok   = {16'd4, 16'd0, 16'd0, 16'd4, 16'd0, 16'd0};
`ifdef RASTER_SCHED_CULL_EN
    exp_valid = 1'b0; exp_cull = 16'd1; exp_tri = 16'd1;
`else
    exp_valid = 1'b1; exp_cull = 16'd0; exp_tri = 16'd2;
`endif
    do_reset();
    drive(1, 0, flat, '0, 0, 0);
    #1;
    n_cmp++; if (b0 !== 1'b0) begin n_err++; $display("FAIL cull_busy got=%b want=0", b0); end
    next_cycle();
    drive(1, 0, ok, '0, 0, 0);
    #1;
    n_cmp++; if (rvalid !== exp_valid) begin n_err++; $display("FAIL cull_valid got=%b want=%b", rvalid, exp_valid); end
    n_cmp++; if (ccnt !== exp_cull) begin n_err++; $display("FAIL cull_count got=%0d want=%0d", ccnt, exp_cull); end
    if (!exp_valid) begin
      next_cycle();
      drive(0, 0, '0, '0, 0, 0);
      #1;
    end else begin
      next_cycle();
      drive(0, 0, '0, '0, 0, 0);
      #1;
    end
    n_cmp++; if (head !== ok) begin n_err++; $display("FAIL cull_ok_head got=%h want=%h", head, ok); end
    next_cycle();
    #1;
    n_cmp++; if (tcnt !== exp_tri) begin n_err++; $display("FAIL cull_tri_count got=%0d want=%0d", tcnt, exp_tri); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int sent = 0;
    do_reset();
    for (int cyc = 0; cyc < 20 && sent < 4; cyc++) begin
      drive(0, 1, '0, good_tri(), 1, 0);
      #1;
      if (!b1) sent++;
      next_cycle();
    end
    drive(0, 0, '0, '0, 0, 0);
    next_cycle();
    rbusy = 1'b1;
    #1;
    n_cmp++; if ({tcnt, rvalid} !== {16'd1, 1'b1}) begin n_err++; $display("FAIL mid_pre got=%0d/%b want=1/1", tcnt, rvalid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({rvalid, idle} !== 2'b01) begin n_err++; $display("FAIL mid_rst got=%b want=01", {rvalid, idle}); end
    n_cmp++; if (head !== 96'd0) begin n_err++; $display("FAIL mid_rst_head got=%h want=0", head); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if ({idle, tcnt, ccnt} !== {1'b1, 32'd0}) begin n_err++; $display("FAIL mid_post got=%b/%0d/%0d want=1/0/0", idle, tcnt, ccnt); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [95:0] q [$];
    logic [95:0] cur0, cur1, t, eh;
    logic        a0, a1, rb, fl, eb0, eb1, ev, full;
    logic [15:0] etc = '0, ecc = '0;
    int          prio = 0;
    int          win;
    do_reset();
    cur0 = rnd_tri();
    cur1 = rnd_tri();
    for (int cyc = 0; cyc < 400; cyc++) begin
      a0 = ($urandom_range(0, 3) != 0);
      a1 = ($urandom_range(0, 3) != 0);
      rb = ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 39) == 0);
      drive(a0, a1, cur0, cur1, rb, fl);
      full = (q.size() == DEPTH);
      win = -1;
      if (a0 && a1) win = prio;
      else if (a0) win = 0;
      else if (a1) win = 1;
      eb0 = full || fl || (win == 1);
      eb1 = full || fl || (win == 0);
      ev  = (q.size() != 0);
      eh  = ev ? q[0] : '0;
      #1;
      n_cmp++; if ({b0, b1} !== {eb0, eb1}) begin n_err++; $display("FAIL rnd_busy[%0d] got=%b want=%b", cyc, {b0, b1}, {eb0, eb1}); end
      n_cmp++; if ({rvalid, idle} !== {ev, !ev}) begin n_err++; $display("FAIL rnd_valid[%0d] got=%b want=%b", cyc, {rvalid, idle}, {ev, !ev}); end
      n_cmp++; if (head !== eh) begin n_err++; $display("FAIL rnd_head[%0d] got=%h want=%h", cyc, head, eh); end
      n_cmp++; if ({tcnt, ccnt} !== {etc, ecc}) begin n_err++; $display("FAIL rnd_counts[%0d] got=%0d/%0d want=%0d/%0d", cyc, tcnt, ccnt, etc, ecc); end
      if (fl) begin
        q.delete();
      end else begin
        if (ev && !rb) begin
          void'(q.pop_front());
          etc++;
          $display("rnd issue cyc=%0d tri=%h", cyc, eh);
        end
        if (win >= 0 && !full) begin
          t = (win == 0) ? cur0 : cur1;
`ifdef RASTER_SCHED_CULL_EN
          if (tri_flat(t)) ecc++;
          else q.push_back(t);
`else
          q.push_back(t);
`endif
          prio = 1 - win;
          if (win == 0) cur0 = rnd_tri();
          else cur1 = rnd_tri();
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure_and_flush();
    test_latency();
    test_cull();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
